// File: rtl/muldiv_pkg.sv
// Shared definitions for the muldiv_unit slice: FSM state encoding, Booth
// recoding operations, counter sizing and the latency constants the bench uses.
// Optional build macro: MULDIV_RADIX4_EN selects the radix-4 Booth multiplier.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W = cnt_width(MD_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      BOOTH_ZERO = 3'd0,
      BOOTH_POS1 = 3'd1,
      BOOTH_NEG1 = 3'd2,
      BOOTH_POS2 = 3'd3,
      BOOTH_NEG2 = 3'd4
   } booth_op_t;

`ifdef MULDIV_RADIX4_EN
   localparam int MUL_LAT = MD_WIDTH / 2 + 1;
`else
   localparam int MUL_LAT = MD_WIDTH + 1;
`endif
   localparam int DIV_LAT = MD_WIDTH + 1;
   localparam int DZ_LAT  = 1;

   // A radix-2 window {q0,q0,q-1} only ever hits the 0/+b/-b rows of this table.
   function automatic booth_op_t booth_decode(input logic [2:0] window);
      booth_op_t op;
      case (window)
         3'b001, 3'b010: op = BOOTH_POS1;
         3'b011:         op = BOOTH_POS2;
         3'b100:         op = BOOTH_NEG2;
         3'b101, 3'b110: op = BOOTH_NEG1;
         default:        op = BOOTH_ZERO;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/muldiv_booth_enc.sv
// Combinational Booth recoder: turns the current multiplier window into the
// addend for the partial product (0, +/-b, and +/-2b in the radix-4 build).
// Optional build macro: MULDIV_RADIX4_EN enables the +/-2b terms.
module muldiv_booth_enc
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       window,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH+1:0] addend
);

   logic [WIDTH+1:0] b_ext;
   logic [WIDTH+1:0] b_dbl;

   assign b_ext = {{2{b[WIDTH-1]}}, b};
   assign b_dbl = {b_ext[WIDTH:0], 1'b0};

   // Select the sign-extended addend for this window.
   always_comb begin
      addend = '0;
      case (booth_decode(window))
         BOOTH_POS1: addend = b_ext;
         BOOTH_NEG1: addend = -b_ext;
`ifdef MULDIV_RADIX4_EN
         BOOTH_POS2: addend = b_dbl;
         BOOTH_NEG2: addend = -b_dbl;
`else
         BOOTH_POS2: addend = '0;
         BOOTH_NEG2: addend = '0;
`endif
         default:    addend = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply/divide engine. Multiply is Booth (radix-2, or
// radix-4 when MULDIV_RADIX4_EN is defined); divide is restoring on magnitudes
// with a sign fix-up on the way into DONE. hi/lo only change on entry to DONE.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mul,
   input  logic             start_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CNT_BITS = cnt_width(WIDTH);
`ifdef MULDIV_RADIX4_EN
   localparam int MUL_STEPS = WIDTH / 2;
`else
   localparam int MUL_STEPS = WIDTH;
`endif
   localparam logic [CNT_BITS-1:0] LAST_MUL = CNT_BITS'(MUL_STEPS - 1);
   localparam logic [CNT_BITS-1:0] LAST_DIV = CNT_BITS'(WIDTH - 1);

   state_t              state;
   logic [CNT_BITS-1:0] cnt;
   logic [WIDTH-1:0]    op_b;
   logic [WIDTH+1:0]    acc_hi;
   logic [WIDTH-1:0]    acc_lo;
   logic                q_m1;
   logic                neg_q;
   logic                neg_r;

   logic [2:0]          booth_window;
   logic [WIDTH+1:0]    booth_addend;
   logic [WIDTH+1:0]    mul_sum;
   logic [WIDTH+1:0]    mul_hi_nx;
   logic [WIDTH-1:0]    mul_lo_nx;
   logic                mul_qm1_nx;

   logic [WIDTH:0]      div_shift;
   logic [WIDTH+1:0]    div_trial;
   logic [WIDTH:0]      div_rem_nx;
   logic [WIDTH-1:0]    div_quo_nx;
   logic [WIDTH-1:0]    div_q_fix;
   logic [WIDTH-1:0]    div_r_fix;

`ifdef MULDIV_RADIX4_EN
   assign booth_window = {acc_lo[1:0], q_m1};
`else
   assign booth_window = {acc_lo[0], acc_lo[0], q_m1};
`endif

   muldiv_booth_enc #(.WIDTH(WIDTH)) u_booth_enc (
      .window (booth_window),
      .b      (op_b),
      .addend (booth_addend)
   );

   // One Booth add-and-arithmetic-shift step over the {acc_hi, acc_lo, q_m1} accumulator.
   always_comb begin
      mul_sum = acc_hi + booth_addend;
`ifdef MULDIV_RADIX4_EN
      mul_hi_nx  = {{2{mul_sum[WIDTH+1]}}, mul_sum[WIDTH+1:2]};
      mul_lo_nx  = {mul_sum[1:0], acc_lo[WIDTH-1:2]};
      mul_qm1_nx = acc_lo[1];
`else
      mul_hi_nx  = {mul_sum[WIDTH+1], mul_sum[WIDTH+1:1]};
      mul_lo_nx  = {mul_sum[0], acc_lo[WIDTH-1:1]};
      mul_qm1_nx = acc_lo[0];
`endif
   end

   // One restoring-divide step; the remainder lives in acc_hi, the dividend/quotient in acc_lo.
   always_comb begin
      div_shift  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      div_trial  = {1'b0, div_shift} - {2'b00, op_b};
      div_rem_nx = div_trial[WIDTH+1] ? div_shift : div_trial[WIDTH:0];
      div_quo_nx = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH+1]};
      div_q_fix  = neg_q ? -div_quo_nx : div_quo_nx;
      div_r_fix  = neg_r ? -div_rem_nx[WIDTH-1:0] : div_rem_nx[WIDTH-1:0];
   end

   // Control FSM with registered busy/done/flag and the final hi/lo result registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         op_b        <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         q_m1        <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start_mul) begin
                  state       <= S_MUL;
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  op_b        <= b;
                  acc_hi      <= '0;
                  acc_lo      <= a;
                  q_m1        <= 1'b0;
                  cnt         <= '0;
               end else if (start_div) begin
                  cnt <= '0;
                  if (b == '0) begin
                     state       <= S_DONE;
                     done        <= 1'b1;
                     hi          <= a;
                     lo          <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     state       <= S_DIV;
                     busy        <= 1'b1;
                     div_by_zero <= 1'b0;
                     op_b        <= b[WIDTH-1] ? -b : b;
                     acc_hi      <= '0;
                     acc_lo      <= a[WIDTH-1] ? -a : a;
                     neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
                     neg_r       <= a[WIDTH-1];
                  end
               end
            end
            S_MUL: begin
               acc_hi <= mul_hi_nx;
               acc_lo <= mul_lo_nx;
               q_m1   <= mul_qm1_nx;
               cnt    <= cnt + CNT_BITS'(1);
               if (cnt == LAST_MUL) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= mul_hi_nx[WIDTH-1:0];
                  lo    <= mul_lo_nx;
               end
            end
            S_DIV: begin
               acc_hi <= {1'b0, div_rem_nx};
               acc_lo <= div_quo_nx;
               cnt    <= cnt + CNT_BITS'(1);
               if (cnt == LAST_DIV) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= div_r_fix;
                  lo    <= div_q_fix;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
